sw_ctrl_fsm: RTL and testbench

Stopwatch control stage sitting directly upstream of `sec_counter`. It conditions two raw pushbuttons (start/stop, clear) with synchronisation, debounce and rising-edge detection. A three-state FSM then drives the 2-bit `en` mode bus that `sec_counter` consumes: T0 = clear, T1 = count, T2 = hold. An optional lap-freeze flag is also produced for the display stage.

---
 rtl/sw_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_sw_ctrl_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sw_ctrl_fsm.sv
// sw_ctrl_fsm: stopwatch control stage feeding sec_counter.
// Two raw pushbuttons (start/stop, clear) are synchronised, debounced and
// edge-detected, then a CLEAR/RUN/PAUSE FSM drives the en mode bus.
// Optional feature macro: SW_CTRL_LAP_EN (lap-freeze toggle on clear in RUN).

// Per-button conditioner: 2-FF sync, counter debounce, rising-edge pulse.
module sw_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic hard_reset,
  input  logic btn_i,
  output logic press_o
);

  logic             s1_q, s2_q;
  logic             db_q, db_dly_q;
  logic [CNT_W-1:0] cnt_q;

  // Sync chain, debounce counter and delayed level for edge detection.
  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any disagreement shorter than DEBOUNCE_CYCLES is lost.
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      db_dly_q <= db_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // One-cycle pulse per accepted press; release is silent.
  assign press_o = db_q & ~db_dly_q;

endmodule

module sw_ctrl_fsm #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [1:0] en,
  output logic       running,
  output logic       lap_active
);

  localparam int NUM_BTN = 2;
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  // Encoding matches the en bus so the output is a straight wire from the
  // state register.
  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic               press_ss, press_clr;
  state_e             state_q, state_d;

  assign btn_raw = {btn_clear, btn_start_stop};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    sw_btn_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cond (
      .clk       (clk),
      .hard_reset(hard_reset),
      .btn_i     (btn_raw[g]),
      .press_o   (press[g])
    );
  end

  assign press_ss  = press[BTN_SS];
  assign press_clr = press[BTN_CLR];

`ifdef SW_CTRL_LAP_EN
  logic lap_q, lap_d;

  // State and lap flag registers.
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q <= CLEAR;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
    end
  end

  // Next state: clear wins over start/stop in PAUSE; clear in RUN toggles lap.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    case (state_q)
      CLEAR: if (press_ss) state_d = RUN;
      RUN: begin
        if (press_ss)       state_d = PAUSE;
        else if (press_clr) lap_d   = ~lap_q;
      end
      PAUSE: begin
        if (press_clr) begin
          state_d = CLEAR;
          lap_d   = 1'b0;
        end else if (press_ss) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = CLEAR;
        lap_d   = 1'b0;
      end
    endcase
  end

  assign lap_active = lap_q;
`else
  // State register.
  always_ff @(posedge clk) begin
    if (hard_reset) state_q <= CLEAR;
    else            state_q <= state_d;
  end

  // Next state: clear wins over start/stop in PAUSE; clear in RUN is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (press_ss) state_d = RUN;
      RUN:   if (press_ss) state_d = PAUSE;
      PAUSE: begin
        if (press_clr)     state_d = CLEAR;
        else if (press_ss) state_d = RUN;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign lap_active = 1'b0;
`endif

  assign en      = state_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_sw_ctrl_fsm.sv
// Bench for sw_ctrl_fsm with DEBOUNCE_CYCLES = 4, 20 ns clock.
// Lap expectations follow SW_CTRL_LAP_EN when the bench is built with it.
module tb_sw_ctrl_fsm;

  localparam int D = 4;
`ifdef SW_CTRL_LAP_EN
  localparam logic L = 1'b1;
`else
  localparam logic L = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       hard_reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [1:0] en;
  logic       running;
  logic       lap_active;

  int n_pass  = 0;
  int n_total = 0;

  sw_ctrl_fsm #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk           (clk),
    .hard_reset    (hard_reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .en            (en),
    .running       (running),
    .lap_active    (lap_active)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       clr;
    int         cyc;
    logic [1:0] en;
    logic       run;
    logic       lap;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic ss, input logic clr, input int c,
                              input logic [1:0] e, input logic r, input logic l);
    vec_t v;
    v.ss = ss; v.clr = clr; v.cyc = c; v.en = e; v.run = r; v.lap = l;
    return v;
  endfunction

  initial begin
    logic saw01;

    // Table starts in CLEAR and ends in RUN with lap = L.
    tbl[0]  = mk(0, 1, 10, 2'b00, 0, 0);  // clear ignored in CLEAR
    tbl[1]  = mk(0, 0, 10, 2'b00, 0, 0);
    tbl[2]  = mk(1, 0, 10, 2'b01, 1, 0);
    tbl[3]  = mk(0, 0, 10, 2'b01, 1, 0);
    tbl[4]  = mk(0, 1, 10, 2'b01, 1, L);  // lap toggle / ignored
    tbl[5]  = mk(0, 0, 10, 2'b01, 1, L);
    tbl[6]  = mk(0, 1, 10, 2'b01, 1, 0);
    tbl[7]  = mk(0, 0, 10, 2'b01, 1, 0);
    tbl[8]  = mk(0, 1, 10, 2'b01, 1, L);
    tbl[9]  = mk(0, 0, 10, 2'b01, 1, L);
    tbl[10] = mk(1, 0, 10, 2'b10, 0, L);  // lap kept into PAUSE
    tbl[11] = mk(0, 0, 10, 2'b10, 0, L);
    tbl[12] = mk(1, 0, 10, 2'b01, 1, L);  // lap kept back into RUN
    tbl[13] = mk(0, 0, 10, 2'b01, 1, L);
    tbl[14] = mk(1, 0, 10, 2'b10, 0, L);
    tbl[15] = mk(0, 0, 10, 2'b10, 0, L);
    tbl[16] = mk(0, 1, 10, 2'b00, 0, 0);  // PAUSE -> CLEAR drops lap
    tbl[17] = mk(0, 0, 10, 2'b00, 0, 0);
    tbl[18] = mk(1, 0, 10, 2'b01, 1, 0);
    tbl[19] = mk(0, 0, 10, 2'b01, 1, 0);
    tbl[20] = mk(0, 1, 10, 2'b01, 1, L);
    tbl[21] = mk(0, 0, 10, 2'b01, 1, L);

    // Reset
    hard_reset = 1'b1; btn_start_stop = 1'b0; btn_clear = 1'b0;
    cyc(1);
    chk("rst_en", en, 0);
    chk("rst_running", running, 0);
    chk("rst_lap", lap_active, 0);
    cyc(1);
    hard_reset = 1'b0;
    cyc(3);

    // Clean press: en flips exactly at edge D+3
    btn_start_stop = 1'b1;
    cyc(D + 2);
    chk("press_before_edge7_en", en, 0);
    cyc(1);
    chk("press_edge7_en", en, 1);
    chk("press_edge7_running", running, 1);
    cyc(20 - (D + 3));
    chk("press_held_en", en, 1);
    btn_start_stop = 1'b0;
    cyc(10);
    chk("release_no_effect_en", en, 1);

    // Bounce: 3 high / 1 low, three times, then stable high
    for (int i = 0; i < 3; i++) begin
      btn_start_stop = 1'b1; cyc(3);
      btn_start_stop = 1'b0; cyc(1);
      chk("bounce_rejected_en", en, 1);
    end
    btn_start_stop = 1'b1;
    cyc(D + 2);
    chk("bounce_final_before_en", en, 1);
    cyc(1);
    chk("bounce_final_edge7_en", en, 2);
    chk("bounce_final_running", running, 0);
    cyc(10);
    chk("bounce_single_transition_en", en, 2);
    btn_start_stop = 1'b0;
    cyc(10);

    // Clear priority in PAUSE: both buttons on the same edge
    btn_start_stop = 1'b1; btn_clear = 1'b1;
    saw01 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (en == 2'b01) saw01 = 1'b1;
      if (k == D + 2) chk("prio_before_en", en, 2);
      if (k == D + 3) chk("prio_edge7_en", en, 0);
    end
    chk("prio_never_run", saw01, 0);
    chk("prio_final_en", en, 0);
    btn_start_stop = 1'b0; btn_clear = 1'b0;
    cyc(10);

    // Table-driven press/release sequence
    for (int i = 0; i < 22; i++) begin
      btn_start_stop = tbl[i].ss;
      btn_clear      = tbl[i].clr;
      cyc(tbl[i].cyc);
      chk($sformatf("vec%0d_en", i), en, tbl[i].en);
      chk($sformatf("vec%0d_running", i), running, tbl[i].run);
      chk($sformatf("vec%0d_lap", i), lap_active, tbl[i].lap);
    end

    // Reset mid-debounce: press progress discarded, state forced to CLEAR
    btn_start_stop = 1'b1;
    cyc(2);
    hard_reset = 1'b1;
    cyc(1);
    chk("midrst_en", en, 0);
    chk("midrst_running", running, 0);
    chk("midrst_lap", lap_active, 0);
    hard_reset = 1'b0;
    cyc(D + 2);
    chk("midrst_before_en", en, 0);
    cyc(1);
    chk("midrst_edge7_en", en, 1);
    chk("midrst_edge7_running", running, 1);
    btn_start_stop = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
